// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Holds the fetch PC, steps it by INCR on every accepted fetch, takes trap and
// branch/jump redirects (trap first), and carries a DEPTH-stage shadow
// pipeline of {pc, valid} so later stages know the PC of the instruction they
// hold. Any redirect flushes the shadow pipeline.
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INCR         = 4,
    parameter int unsigned     ALIGN_BITS   = 2,
    parameter int unsigned     DEPTH        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  fetch_ready,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_target,
    input  logic                  trap_valid,
    input  logic [XLEN-1:0]       trap_vector,
    output logic [XLEN-1:0]       pc_o,
    output logic                  fetch_valid_o,
    output logic                  misaligned_o,
    output logic [DEPTH*XLEN-1:0] pipe_pc_o,
    output logic [DEPTH-1:0]      pipe_valid_o
);

    // Low bits that a loaded target must have cleared.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);
    localparam logic [XLEN-1:0] INCR_W     = XLEN'(INCR);

    logic [XLEN-1:0]             pc_q, pc_d;
    logic                        fetch_valid_q, fetch_valid_d;
    logic                        misaligned_q, misaligned_d;
    logic [DEPTH-1:0][XLEN-1:0]  pipe_pc_q, pipe_pc_d;
    logic [DEPTH-1:0]            pipe_valid_q, pipe_valid_d;

    logic                        acc;
    logic                        flush;
    logic [XLEN-1:0]             target;

    // Fetch handshake and redirect source selection (trap beats branch).
    always_comb begin
        acc    = fetch_valid_q & fetch_ready & ~stall;
        flush  = trap_valid | redirect_valid;
        target = trap_valid ? trap_vector : redirect_target;
    end

    // Next fetch PC: redirects override stall; increment wraps modulo 2^XLEN.
    always_comb begin
        pc_d          = pc_q;
        fetch_valid_d = 1'b1;
        misaligned_d  = 1'b0;
        if (flush) begin
            pc_d         = target & ~ALIGN_MASK;
            misaligned_d = (target & ALIGN_MASK) != '0;
        end else if (acc) begin
            pc_d = pc_q + INCR_W;
        end
    end

    // Shadow pipeline: flush drops valids, stall freezes, otherwise shift in
    // the pre-increment PC tagged with whether it was accepted.
    always_comb begin
        pipe_pc_d    = pipe_pc_q;
        pipe_valid_d = pipe_valid_q;
        if (flush) begin
            pipe_valid_d = '0;
        end else if (!stall) begin
            pipe_pc_d[0]    = pc_q;
            pipe_valid_d[0] = acc;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_pc_d[i]    = pipe_pc_q[i-1];
                pipe_valid_d[i] = pipe_valid_q[i-1];
            end
        end
    end

    // State registers; synchronous reset clears everything including PCs so
    // nothing downstream ever sees X after the first reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            pipe_pc_q     <= '0;
            pipe_valid_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            misaligned_q  <= misaligned_d;
            pipe_pc_q     <= pipe_pc_d;
            pipe_valid_q  <= pipe_valid_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = fetch_valid_q;
    assign misaligned_o  = misaligned_q;
    assign pipe_pc_o     = pipe_pc_q;
    assign pipe_valid_o  = pipe_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: a behavioural model pushes the expected post-edge
// state to a scoreboard queue as each cycle's stimulus is driven; scenario
// tasks pop it after the edge and also check the literal values expected by
// the directed scenarios.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, stall, fetch_ready, redirect_valid, trap_valid;
    logic [31:0] redirect_target, trap_vector;
    logic [31:0] pc_o;
    logic        fetch_valid_o, misaligned_o;
    logic [95:0] pipe_pc_o;
    logic [2:0]  pipe_valid_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]       pc;
        logic              fv;
        logic              mis;
        logic [2:0]        pv;
        logic [2:0][31:0]  ppc;
    } exp_t;

    exp_t sb[$];

    // Model state
    logic [31:0]      m_pc;
    logic             m_fv, m_mis;
    logic [2:0]       m_pv;
    logic [2:0][31:0] m_ppc;

    pc_gen #(
        .XLEN(32), .RESET_VECTOR(RV), .INCR(4), .ALIGN_BITS(2), .DEPTH(3)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .pc_o(pc_o), .fetch_valid_o(fetch_valid_o), .misaligned_o(misaligned_o),
        .pipe_pc_o(pipe_pc_o), .pipe_valid_o(pipe_valid_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, push its expectation,
    // then step past the clock edge.
    task automatic cyc(input logic r, input logic st, input logic rdy,
                       input logic rv, input logic [31:0] rt,
                       input logic tv, input logic [31:0] tvec);
        exp_t e;
        logic a;
        rst = r; stall = st; fetch_ready = rdy;
        redirect_valid = rv; redirect_target = rt;
        trap_valid = tv; trap_vector = tvec;
        a = m_fv & rdy & ~st;
        if (r) begin
            m_pc = RV; m_fv = 1'b0; m_mis = 1'b0; m_pv = '0; m_ppc = '0;
        end else begin
            m_mis = tv ? (tvec[1:0] != 2'b00) : (rv ? (rt[1:0] != 2'b00) : 1'b0);
            if (tv || rv) m_pv = '0;
            else if (!st) begin
                m_ppc = {m_ppc[1:0], m_pc};
                m_pv  = {m_pv[1:0], a};
            end
            if (tv)      m_pc = {tvec[31:2], 2'b00};
            else if (rv) m_pc = {rt[31:2], 2'b00};
            else if (a)  m_pc = m_pc + 32'd4;
            m_fv = 1'b1;
        end
        e.pc = m_pc; e.fv = m_fv; e.mis = m_mis; e.pv = m_pv; e.ppc = m_ppc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        cyc(1, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        cyc(1, 0, 1, 1, 32'h2000, 0, 0);
        e = sb.pop_front();
        checks++; if (pc_o !== 32'h1000) begin errors++; $display("FAIL reset_pc actual=%h required=%h", pc_o, 32'h1000); end
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fv actual=%b required=0", fetch_valid_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_mis actual=%b required=0", misaligned_o); end
        checks++; if (pipe_valid_o !== 3'b000) begin errors++; $display("FAIL reset_pv actual=%b required=000", pipe_valid_o); end
        checks++; if (pipe_pc_o !== 96'h0) begin errors++; $display("FAIL reset_ppc actual=%h required=0", pipe_pc_o); end
        checks++; if (pc_o !== e.pc) begin errors++; $display("FAIL reset_model_pc actual=%h required=%h", pc_o, e.pc); end
    endtask

    task automatic test_sequential();
        logic [31:0] want_pc[3];
        logic [2:0]  want_pv[3];
        exp_t e;
        want_pc[0] = 32'h1000; want_pc[1] = 32'h1004; want_pc[2] = 32'h1008;
        want_pv[0] = 3'b000;   want_pv[1] = 3'b001;   want_pv[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            e = sb.pop_front();
            checks++; if (pc_o !== want_pc[i]) begin errors++; $display("FAIL seq_pc%0d actual=%h required=%h", i, pc_o, want_pc[i]); end
            checks++; if (pipe_valid_o !== want_pv[i]) begin errors++; $display("FAIL seq_pv%0d actual=%b required=%b", i, pipe_valid_o, want_pv[i]); end
            checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL seq_fv%0d actual=%b required=1", i, fetch_valid_o); end
            checks++; if (pc_o !== e.pc) begin errors++; $display("FAIL seq_model_pc%0d actual=%h required=%h", i, pc_o, e.pc); end
        end
        checks++; if (pipe_pc_o[31:0] !== 32'h1004 || pipe_pc_o[63:32] !== 32'h1000) begin
            errors++; $display("FAIL seq_ppc actual=%h required=..._00001000_00001004", pipe_pc_o[63:0]);
        end
    endtask

    task automatic test_stall();
        logic [95:0] ppc_before;
        exp_t e;
        ppc_before = pipe_pc_o;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 0, 0, 0);
            e = sb.pop_front();
            checks++; if (pc_o !== 32'h1008) begin errors++; $display("FAIL stall_pc%0d actual=%h required=%h", i, pc_o, 32'h1008); end
            checks++; if (pipe_valid_o !== 3'b011) begin errors++; $display("FAIL stall_pv%0d actual=%b required=011", i, pipe_valid_o); end
            checks++; if (pipe_pc_o !== ppc_before) begin errors++; $display("FAIL stall_ppc%0d actual=%h required=%h", i, pipe_pc_o, ppc_before); end
            checks++; if (pc_o !== e.pc) begin errors++; $display("FAIL stall_model_pc%0d actual=%h required=%h", i, pc_o, e.pc); end
        end
        cyc(0, 0, 1, 0, 0, 0, 0);
        void'(sb.pop_front());
        checks++; if (pc_o !== 32'h100C) begin errors++; $display("FAIL stall_release_pc actual=%h required=%h", pc_o, 32'h100C); end
        checks++; if (pipe_valid_o !== 3'b111) begin errors++; $display("FAIL stall_release_pv actual=%b required=111", pipe_valid_o); end
        checks++; if (pipe_pc_o !== {32'h1000, 32'h1004, 32'h1008}) begin
            errors++; $display("FAIL stall_release_ppc actual=%h required=%h", pipe_pc_o, {32'h1000, 32'h1004, 32'h1008});
        end
    endtask

    task automatic test_redirect();
        cyc(0, 0, 1, 1, 32'h2000, 0, 0);
        void'(sb.pop_front());
        checks++; if (pc_o !== 32'h2000) begin errors++; $display("FAIL redir_pc actual=%h required=%h", pc_o, 32'h2000); end
        checks++; if (pipe_valid_o !== 3'b000) begin errors++; $display("FAIL redir_pv actual=%b required=000", pipe_valid_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL redir_mis actual=%b required=0", misaligned_o); end
        checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL redir_fv actual=%b required=1", fetch_valid_o); end
        cyc(0, 0, 1, 0, 0, 0, 0);
        void'(sb.pop_front());
        checks++; if (pc_o !== 32'h2004) begin errors++; $display("FAIL redir_resume_pc actual=%h required=%h", pc_o, 32'h2004); end
        checks++; if (pipe_valid_o !== 3'b001 || pipe_pc_o[31:0] !== 32'h2000) begin
            errors++; $display("FAIL redir_resume_pipe actual=%b/%h required=001/00002000", pipe_valid_o, pipe_pc_o[31:0]);
        end
    endtask

    task automatic test_trap_vs_redirect();
        cyc(0, 1, 1, 1, 32'h2000, 1, 32'h80);
        void'(sb.pop_front());
        checks++; if (pc_o !== 32'h80) begin errors++; $display("FAIL trap_pc actual=%h required=%h", pc_o, 32'h80); end
        checks++; if (pipe_valid_o !== 3'b000) begin errors++; $display("FAIL trap_pv actual=%b required=000", pipe_valid_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL trap_mis actual=%b required=0", misaligned_o); end
    endtask

    task automatic test_misalign();
        cyc(0, 0, 0, 1, 32'h3006, 0, 0);
        void'(sb.pop_front());
        checks++; if (pc_o !== 32'h3004) begin errors++; $display("FAIL mis_pc actual=%h required=%h", pc_o, 32'h3004); end
        checks++; if (misaligned_o !== 1'b1) begin errors++; $display("FAIL mis_pulse actual=%b required=1", misaligned_o); end
        cyc(0, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL mis_clear actual=%b required=0", misaligned_o); end
        cyc(0, 0, 0, 0, 0, 1, 32'h0000_0101);
        void'(sb.pop_front());
        checks++; if (pc_o !== 32'h100 || misaligned_o !== 1'b1) begin
            errors++; $display("FAIL mis_trap actual=%h/%b required=00000100/1", pc_o, misaligned_o);
        end
    endtask

    task automatic test_wrap();
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        void'(sb.pop_front());
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_load actual=%h required=fffffffc", pc_o); end
        cyc(0, 0, 1, 0, 0, 0, 0);
        void'(sb.pop_front());
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc actual=%h required=00000000", pc_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL wrap_flag actual=%b required=0", misaligned_o); end
        checks++; if (pipe_valid_o[0] !== 1'b1 || pipe_pc_o[31:0] !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_pipe actual=%b/%h required=1/fffffffc", pipe_valid_o[0], pipe_pc_o[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic r, st, rdy, rv, tv;
        logic [31:0] rt, tvec;
        for (int n = 0; n < 400; n++) begin
            r    = ($urandom_range(0, 49) == 0);
            st   = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 3) != 0);
            rv   = ($urandom_range(0, 7) == 0);
            tv   = ($urandom_range(0, 15) == 0);
            rt   = $urandom;
            tvec = $urandom;
            cyc(r, st, rdy, rv, rt, tv, tvec);
            e = sb.pop_front();
            checks++; if (pc_o !== e.pc) begin errors++; $display("FAIL b2b_pc cyc=%0d actual=%h required=%h", n, pc_o, e.pc); end
            checks++; if (fetch_valid_o !== e.fv) begin errors++; $display("FAIL b2b_fv cyc=%0d actual=%b required=%b", n, fetch_valid_o, e.fv); end
            checks++; if (misaligned_o !== e.mis) begin errors++; $display("FAIL b2b_mis cyc=%0d actual=%b required=%b", n, misaligned_o, e.mis); end
            checks++; if (pipe_valid_o !== e.pv) begin errors++; $display("FAIL b2b_pv cyc=%0d actual=%b required=%b", n, pipe_valid_o, e.pv); end
            for (int i = 0; i < 3; i++) begin
                if (e.pv[i]) begin
                    checks++;
                    if (pipe_pc_o[i*32 +: 32] !== e.ppc[i]) begin
                        errors++; $display("FAIL b2b_ppc%0d cyc=%0d actual=%h required=%h", i, n, pipe_pc_o[i*32 +: 32], e.ppc[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 1, 0, 0, 0, 0);
        void'(sb.pop_front());
        cyc(0, 0, 1, 0, 0, 0, 0);
        void'(sb.pop_front());
        cyc(1, 1, 1, 1, 32'h5556, 1, 32'h0000_0003);
        void'(sb.pop_front());
        checks++; if (pc_o !== RV) begin errors++; $display("FAIL midrst_pc actual=%h required=%h", pc_o, RV); end
        checks++; if (fetch_valid_o !== 1'b0 || misaligned_o !== 1'b0) begin
            errors++; $display("FAIL midrst_flags actual=%b%b required=00", fetch_valid_o, misaligned_o);
        end
        checks++; if (pipe_valid_o !== 3'b000 || pipe_pc_o !== 96'h0) begin
            errors++; $display("FAIL midrst_pipe actual=%b/%h required=000/0", pipe_valid_o, pipe_pc_o);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; fetch_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; trap_vector = '0;
        m_pc = 'x; m_fv = 'x; m_mis = 'x; m_pv = 'x; m_ppc = 'x;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_trap_vs_redirect();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
